seq_array_multiplier: RTL

SEQ_ARRAY_MULTIPLIER -- requirements
Module: seq_array_multiplier

---
 rtl/seq_array_mul_pkg.sv | 21 ++
 rtl/seq_array_multiplier_mul_row.sv | 30 +++
 rtl/seq_array_multiplier.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/seq_array_mul_pkg.sv
// Shared types and helpers for the sequential array multiplier.
// The state enum is also used by the debug state output of the top level.
package seq_array_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to hold the values 0..n, i.e. ceil(log2(n+1)), never below 1.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < (n + 1)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_array_multiplier_mul_row.sv
// One partial-product row of the array: W AND gates feeding a ripple chain
// of full adders. Adds (a & {W{b_bit}}) to the incoming partial sum.
// Purely combinational; the carry out becomes the row's top bit.
module mul_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] pp_in,
  input  logic [W-1:0] a_in,
  input  logic         b_bit,
  output logic [W-1:0] sum_out,
  output logic         carry_out
);

  logic carry;
  logic pp_bit;

  // AND/full-adder slices, LSB slice first, carry rippling upward.
  always_comb begin
    sum_out = '0;
    carry   = 1'b0;
    pp_bit  = 1'b0;
    for (int i = 0; i < W; i++) begin
      pp_bit     = a_in[i] & b_bit;
      sum_out[i] = pp_in[i] ^ pp_bit ^ carry;
      carry      = (pp_in[i] & pp_bit) | (pp_in[i] & carry) | (pp_bit & carry);
    end
    carry_out = carry;
  end

endmodule

// File: rtl/seq_array_multiplier.sv
// Sequential array multiplier: retires ROWS_PER_CYCLE partial-product rows
// per clock into a 2*MUL_WIDTH-bit accumulator, LSB row first.
// The accumulator is kept as {hi, lo}: each row adds into hi and shifts one
// finished product bit out into the top of lo, so after N = MUL_WIDTH /
// ROWS_PER_CYCLE RUN cycles {hi, lo} holds the full product.
// Optional feature: define SEQ_ARRAY_MUL_SIGNED_EN to honour signed_in
// (two's-complement operands via magnitude conversion and final negation).
// Without it signed_in is ignored and no sign logic is built.
//
// Handshake: start_in is accepted on any rising edge where the block is in
// IDLE or DONE and rst_in is low; busy_out is high for exactly the N RUN
// cycles, and done_out pulses for one cycle with m_out valid. m_out then
// holds until the next DONE or reset.
module seq_array_multiplier
  import seq_array_mul_pkg::*;
#(
  parameter int MUL_WIDTH      = 8,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  input  logic                     signed_in,
  input  logic [MUL_WIDTH-1:0]     a_in,
  input  logic [MUL_WIDTH-1:0]     b_in,
  output logic                     busy_out,
  output logic                     done_out,
  output logic [2*MUL_WIDTH-1:0]   m_out,
  output state_t                   state_dbg_out
);

  localparam int W     = MUL_WIDTH;
  localparam int R     = ROWS_PER_CYCLE;
  localparam int N     = W / R;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       mplier_q, mplier_d;
  logic [2*W-1:0]     acc_q, acc_d;
  logic [2*W-1:0]     m_q, m_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               load;
  logic [W-1:0]       a_load;
  logic [W-1:0]       b_load;
  logic [2*W-1:0]     step_acc;
  logic [2*W-1:0]     result;
  logic [W-1:0]       hi_next;
  logic [W-1:0]       lo_next;
  logic [R-1:0]       row_lsb;

  // A start is taken whenever the FSM is not busy; reset priority is in the flops.
  assign load = start_in && (state_q != RUN);

  // Cascade of R rows; row i consumes multiplier bit i of the shifting copy.
  for (genvar i = 0; i < R; i++) begin : g_row
    logic [W-1:0] pp_in;
    logic [W-1:0] sum;
    logic         cout;

    if (i == 0) begin : g_first
      assign pp_in = acc_q[2*W-1:W];
    end else begin : g_next
      assign pp_in = {g_row[i-1].cout, g_row[i-1].sum[W-1:1]};
    end

    mul_row #(.W(W)) u_row (
      .pp_in     (pp_in),
      .a_in      (a_q),
      .b_bit     (mplier_q[i]),
      .sum_out   (sum),
      .carry_out (cout)
    );

    assign row_lsb[i] = sum[0];
  end

  assign hi_next = {g_row[R-1].cout, g_row[R-1].sum[W-1:1]};

  // Shift the R finished product bits into the top of the low half.
  always_comb begin
    lo_next = acc_q[W-1:0] >> R;
    for (int i = 0; i < R; i++) begin
      lo_next[W-R+i] = row_lsb[i];
    end
    step_acc = {hi_next, lo_next};
  end

`ifdef SEQ_ARRAY_MUL_SIGNED_EN
  logic neg_q, neg_d;
  logic a_neg, b_neg;

  // Signed operands are stored as magnitudes; the product sign is kept aside.
  always_comb begin
    a_neg  = signed_in & a_in[W-1];
    b_neg  = signed_in & b_in[W-1];
    a_load = a_neg ? -a_in : a_in;
    b_load = b_neg ? -b_in : b_in;
    neg_d  = neg_q;
    if (load) neg_d = a_neg ^ b_neg;
    result = neg_q ? -step_acc : step_acc;
  end

  // Result-sign flop, cleared by reset like the other operand state.
  always_ff @(posedge clk_in) begin
    if (rst_in) neg_q <= 1'b0;
    else        neg_q <= neg_d;
  end
`else
  logic unused_signed;
  assign unused_signed = signed_in;

  // Unsigned-only build: operands and product pass straight through.
  always_comb begin
    a_load = a_in;
    b_load = b_in;
    result = step_acc;
  end
`endif

  // Next-state and datapath control for IDLE -> RUN (N cycles) -> DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    m_d      = m_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (load) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          cnt_d    = '0;
          a_d      = a_load;
          mplier_d = b_load;
          acc_d    = '0;
        end
      end
      RUN: begin
        busy_d   = 1'b1;
        acc_d    = step_acc;
        mplier_d = mplier_q >> R;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          m_d     = result;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand, accumulator and registered-output flops.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      m_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign m_out         = m_q;
  assign state_dbg_out = state_q;

endmodule
